// File: rtl/ili9341_sprite_scaler.sv
// ili9341_sprite_scaler: streams one DISP_W x DISP_H RGB565 frame per request.
// The frame is built from a sprite ROM with integer nearest-neighbour upscaling.
// The sprite is centred on the display, and pixels outside it take BG_COLOR.
// The sprite image is latched at frame start; img_sel changes take effect on the next frame.
// Optional feature macro: SPRITE_KEY_EN (ROM words equal to KEY_COLOR render as BG_COLOR).
//
// state | meaning
// IDLE  | latch image, clear frame_done, restart raster at (0,0)
// FETCH | mem_addr presents the current pixel's ROM address
// WAIT  | ROM word valid; register pix_data (sprite or fill) and raise pix_valid
// SHOW  | hold pixel until accepted, then advance raster
// DONE  | frame finished; wait for a new image request
module ili9341_sprite_scaler #(
   parameter int DISP_W     = 240,
   parameter int DISP_H     = 240,
   parameter int SRC_W      = 80,
   parameter int SRC_H      = 80,
   parameter int SCALE      = 3,
   parameter int N_IMG      = 14,
   parameter int PIXEL_SIZE = 16,
   parameter logic [PIXEL_SIZE-1:0] BG_COLOR  = 16'h001F,
   parameter logic [PIXEL_SIZE-1:0] KEY_COLOR = 16'hF81F,
   localparam int SELW   = (N_IMG > 1) ? $clog2(N_IMG) : 1,
   localparam int ADDR_W = (N_IMG*SRC_W*SRC_H > 1) ? $clog2(N_IMG*SRC_W*SRC_H) : 1
) (
   input  logic                  clk_out,
   input  logic                  rst,
   input  logic [SELW-1:0]       img_sel,
   input  logic                  pix_ready,
   output logic                  pix_valid,
   output logic [PIXEL_SIZE-1:0] pix_data,
   output logic                  frame_done,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [PIXEL_SIZE-1:0] mem_data
);

   localparam int XW  = (DISP_W > 1) ? $clog2(DISP_W) : 1;
   localparam int YW  = (DISP_H > 1) ? $clog2(DISP_H) : 1;
   localparam int SXW = (SRC_W > 1)  ? $clog2(SRC_W)  : 1;
   localparam int SYW = (SRC_H > 1)  ? $clog2(SRC_H)  : 1;
   localparam int SBW = (SCALE > 1)  ? $clog2(SCALE)  : 1;

   localparam logic [XW:0]       X0_C     = (XW+1)'((DISP_W - SRC_W*SCALE) / 2);
   localparam logic [YW:0]       Y0_C     = (YW+1)'((DISP_H - SRC_H*SCALE) / 2);
   localparam logic [XW:0]       WIN_W_C  = (XW+1)'(SRC_W*SCALE);
   localparam logic [YW:0]       WIN_H_C  = (YW+1)'(SRC_H*SCALE);
   localparam logic [XW-1:0]     X_LAST   = XW'(DISP_W - 1);
   localparam logic [YW-1:0]     Y_LAST   = YW'(DISP_H - 1);
   localparam logic [SXW-1:0]    SX_LAST  = SXW'(SRC_W - 1);
   localparam logic [SYW-1:0]    SY_LAST  = SYW'(SRC_H - 1);
   localparam logic [SBW-1:0]    SUB_LAST = SBW'(SCALE - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);
   localparam logic [ADDR_W-1:0] IMG_SZ_C = ADDR_W'(SRC_W*SRC_H);
   localparam logic [SELW:0]     N_IMG_C  = (SELW+1)'(N_IMG);

   generate
      if (SCALE < 1 || SRC_W*SCALE > DISP_W || SRC_H*SCALE > DISP_H) begin : g_param_check
         $error("ili9341_sprite_scaler: scaled sprite does not fit the display");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SHOW, S_DONE} state_t;

   state_t                r_state;
   logic [XW-1:0]         r_x;
   logic [YW-1:0]         r_y;
   logic [SBW-1:0]        r_subx, r_suby;
   logic [SXW-1:0]        r_sx;
   logic [SYW-1:0]        r_sy;
   logic [ADDR_W-1:0]     r_row_base, r_img_base, r_mem_addr;
   logic [SELW-1:0]       r_img_lat, r_sel_prev;
   logic                  r_pending, r_pix_valid, r_frame_done;
   logic [PIXEL_SIZE-1:0] r_pix_data;

   logic [XW:0]           w_dx;
   logic [YW:0]           w_dy;
   logic                  w_in_x, w_in_y, w_last_col, w_last_row, w_sel_chg, w_key_hit;
   logic [XW-1:0]         w_x_nx;
   logic [YW-1:0]         w_y_nx;
   logic [SBW-1:0]        w_subx_nx, w_suby_nx;
   logic [SXW-1:0]        w_sx_nx;
   logic [SYW-1:0]        w_sy_nx;
   logic [ADDR_W-1:0]     w_row_nx, w_addr_cur, w_addr_nxt, w_sel_base;
   logic [SELW-1:0]       w_sel_idx;
   logic [PIXEL_SIZE-1:0] w_pix_sel;

   // Pixels left or above the window wrap to large values thanks to the guard bit.
   assign w_dx       = {1'b0, r_x} - X0_C;
   assign w_dy       = {1'b0, r_y} - Y0_C;
   assign w_in_x     = (w_dx < WIN_W_C);
   assign w_in_y     = (w_dy < WIN_H_C);
   assign w_last_col = (r_x == X_LAST);
   assign w_last_row = (r_y == Y_LAST);
   assign w_sel_chg  = (img_sel != r_sel_prev);
   assign w_key_hit  = (mem_data == KEY_COLOR);

   assign w_sel_idx  = ({1'b0, img_sel} >= N_IMG_C) ? '0 : img_sel;
   assign w_sel_base = ADDR_W'(w_sel_idx) * IMG_SZ_C;
   assign w_addr_cur = r_img_base + r_row_base + ADDR_W'(r_sx);
   assign w_addr_nxt = r_img_base + w_row_nx + ADDR_W'(w_sx_nx);

   // Next raster/source position; sx and sy saturate so the address never leaves the image.
   always_comb begin
      w_x_nx    = r_x;
      w_y_nx    = r_y;
      w_subx_nx = r_subx;
      w_suby_nx = r_suby;
      w_sx_nx   = r_sx;
      w_sy_nx   = r_sy;
      w_row_nx  = r_row_base;
      if (w_last_col) begin
         w_x_nx    = '0;
         w_subx_nx = '0;
         w_sx_nx   = '0;
         if (w_last_row) begin
            w_y_nx    = '0;
            w_suby_nx = '0;
            w_sy_nx   = '0;
            w_row_nx  = '0;
         end else begin
            w_y_nx = r_y + 1'b1;
            if (w_in_y) begin
               if (r_suby == SUB_LAST) begin
                  w_suby_nx = '0;
                  if (r_sy != SY_LAST) begin
                     w_sy_nx  = r_sy + 1'b1;
                     w_row_nx = r_row_base + ROW_STEP;
                  end
               end else begin
                  w_suby_nx = r_suby + 1'b1;
               end
            end
         end
      end else begin
         w_x_nx = r_x + 1'b1;
         if (w_in_x) begin
            if (r_subx == SUB_LAST) begin
               w_subx_nx = '0;
               if (r_sx != SX_LAST) w_sx_nx = r_sx + 1'b1;
            end else begin
               w_subx_nx = r_subx + 1'b1;
            end
         end
      end
   end

   // Pixel colour for the current raster position from the ROM word.
   always_comb begin
      w_pix_sel = BG_COLOR;
      if (w_in_x && w_in_y) begin
`ifdef SPRITE_KEY_EN
         w_pix_sel = w_key_hit ? BG_COLOR : mem_data;
`else
         // Key word passes through unchanged.
         w_pix_sel = w_key_hit ? KEY_COLOR : mem_data;
`endif
      end
   end

   // Frame sequencer with registered outputs.
   always_ff @(posedge clk_out) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_subx       <= '0;
         r_suby       <= '0;
         r_sx         <= '0;
         r_sy         <= '0;
         r_row_base   <= '0;
         r_img_base   <= '0;
         r_img_lat    <= '0;
         r_sel_prev   <= img_sel;
         r_pending    <= 1'b0;
         r_pix_valid  <= 1'b0;
         r_pix_data   <= '0;
         r_frame_done <= 1'b0;
         r_mem_addr   <= '0;
      end else begin
         r_sel_prev <= img_sel;
         case (r_state)
            S_IDLE: begin
               r_img_lat    <= img_sel;
               r_img_base   <= w_sel_base;
               r_mem_addr   <= w_sel_base;
               r_x          <= '0;
               r_y          <= '0;
               r_subx       <= '0;
               r_suby       <= '0;
               r_sx         <= '0;
               r_sy         <= '0;
               r_row_base   <= '0;
               r_frame_done <= 1'b0;
               r_pending    <= 1'b0;
               r_pix_valid  <= 1'b0;
               r_state      <= S_FETCH;
            end
            S_FETCH: begin
               r_mem_addr <= w_addr_cur;
               if (w_sel_chg) r_pending <= 1'b1;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_pix_data  <= w_pix_sel;
               r_pix_valid <= 1'b1;
               if (w_sel_chg) r_pending <= 1'b1;
               r_state <= S_SHOW;
            end
            S_SHOW: begin
               if (w_sel_chg) r_pending <= 1'b1;
               if (r_pix_valid && pix_ready) begin
                  r_pix_valid <= 1'b0;
                  r_x         <= w_x_nx;
                  r_y         <= w_y_nx;
                  r_subx      <= w_subx_nx;
                  r_suby      <= w_suby_nx;
                  r_sx        <= w_sx_nx;
                  r_sy        <= w_sy_nx;
                  r_row_base  <= w_row_nx;
                  if (w_last_col && w_last_row) begin
                     r_mem_addr   <= '0;
                     r_frame_done <= 1'b1;
                     r_state      <= S_DONE;
                  end else begin
                     r_mem_addr <= w_addr_nxt;
                     r_state    <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               r_pix_valid  <= 1'b0;
               r_mem_addr   <= '0;
               r_frame_done <= 1'b1;
               if (r_pending || (img_sel != r_img_lat)) begin
                  r_pending <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pix_valid  = r_pix_valid;
   assign pix_data   = r_pix_data;
   assign frame_done = r_frame_done;
   assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_ili9341_sprite_scaler.sv
// Bench for ili9341_sprite_scaler: 8x8 display, 2x2 sprites, scale 3.
// Three images are stored so img_sel is two bits wide and index 3 is out of range.
module tb_ili9341_sprite_scaler;

   localparam int DW = 8, DH = 8, SW = 2, SH = 2, SC = 3, NI = 3;
   localparam int NPIX = DW*DH;
   localparam logic [15:0] BG  = 16'h001F;
   localparam logic [15:0] KEY = 16'hF81F;

   logic        clk_out = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  img_sel = 2'd0;
   logic        pix_ready = 1'b1;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        frame_done;
   logic [3:0]  mem_addr;
   logic [15:0] mem_data;

   logic [15:0] rom [16];
   int n_checks = 0;
   int n_pass   = 0;

   ili9341_sprite_scaler #(
      .DISP_W(DW), .DISP_H(DH), .SRC_W(SW), .SRC_H(SH), .SCALE(SC), .N_IMG(NI),
      .PIXEL_SIZE(16), .BG_COLOR(BG), .KEY_COLOR(KEY)
   ) dut (
      .clk_out(clk_out), .rst(rst), .img_sel(img_sel), .pix_ready(pix_ready),
      .pix_valid(pix_valid), .pix_data(pix_data), .frame_done(frame_done),
      .mem_addr(mem_addr), .mem_data(mem_data)
   );

   always #5 clk_out = ~clk_out;

   // Registered ROM, one-cycle read latency.
   always @(posedge clk_out) mem_data <= rom[mem_addr];

   // Reference: expected colour of display pixel (x,y) for image img.
   function automatic logic [15:0] exp_pix(input int img, input int x, input int y);
      int k, ox, oy;
      logic [15:0] v;
      k  = (img >= NI) ? 0 : img;
      ox = (DW - SW*SC) / 2;
      oy = (DH - SH*SC) / 2;
      if (x >= ox && x < ox + SW*SC && y >= oy && y < oy + SH*SC) begin
         v = rom[k*SW*SH + ((y - oy) / SC) * SW + (x - ox) / SC];
`ifdef SPRITE_KEY_EN
         if (v == KEY) v = BG;
`endif
         return v;
      end
      return BG;
   endfunction

   task automatic fill_rom();
      for (int i = 0; i < 16; i++) begin
         rom[i] = 16'($urandom);
         if (rom[i] == KEY || rom[i] == BG) rom[i] = rom[i] ^ 16'h0100;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk_out);
      rst = 1'b0;
      repeat (2) @(negedge clk_out);
      rst = 1'b1;
   endtask

   task automatic stream_frame(input int img, input int stall_idx, input int stall_len,
                               input int chg_idx, input int chg_val, input int abort_idx,
                               input int addr_max, input bit chk_lat);
      for (int p = 0; p < NPIX; p++) begin
         int w = 0;
         int lat;
         logic [15:0] held, e;
         while (!pix_valid && w < 20) begin
            @(negedge clk_out);
            w++;
            if (addr_max >= 0) begin
               n_checks++;
               if (int'(mem_addr) > addr_max)
                  $display("FAIL mem_addr_range: got %0d, limit %0d", mem_addr, addr_max);
               else n_pass++;
            end
         end
         n_checks++;
         if (!pix_valid) begin
            $display("FAIL pix_valid_timeout: pixel %0d got valid=0 required 1", p);
            return;
         end else n_pass++;
         e = exp_pix(img, p % DW, p / DW);
         n_checks++;
         if (pix_data !== e)
            $display("FAIL pix_data p%0d (%0d,%0d): got %h expected %h", p, p % DW, p / DW, pix_data, e);
         else n_pass++;
         if (p == abort_idx) begin
            rst = 1'b0;
            @(negedge clk_out);
            n_checks++;
            if (pix_valid !== 1'b0 || pix_data !== 16'h0 || frame_done !== 1'b0 || mem_addr !== 4'h0)
               $display("FAIL mid_reset: got v=%b d=%h fd=%b a=%h expected 0 0000 0 0",
                        pix_valid, pix_data, frame_done, mem_addr);
            else n_pass++;
            rst = 1'b1;
            return;
         end
         if (p == stall_idx) begin
            held = pix_data;
            pix_ready = 1'b0;
            repeat (stall_len) begin
               @(negedge clk_out);
               n_checks++;
               if (pix_valid !== 1'b1 || pix_data !== held)
                  $display("FAIL stall_hold: got v=%b d=%h expected 1 %h", pix_valid, pix_data, held);
               else n_pass++;
            end
            pix_ready = 1'b1;
         end
         if (p == chg_idx) img_sel = 2'(chg_val);
         @(negedge clk_out);
         if (p == NPIX - 1) begin
            n_checks++;
            if (frame_done !== 1'b1 || pix_valid !== 1'b0)
               $display("FAIL frame_done_last: got fd=%b v=%b expected 1 0", frame_done, pix_valid);
            else n_pass++;
         end else if (chk_lat) begin
            lat = 1;
            while (!pix_valid && lat < 10) begin
               @(negedge clk_out);
               lat++;
            end
            n_checks++;
            if (lat != 3)
               $display("FAIL latency p%0d: got %0d cycles expected 2", p, lat - 1);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset();
      fill_rom();
      img_sel = 2'd0;
      pix_ready = 1'b1;
      rst = 1'b0;
      repeat (3) @(negedge clk_out);
      n_checks++;
      if (pix_valid !== 1'b0 || pix_data !== 16'h0 || frame_done !== 1'b0 || mem_addr !== 4'h0)
         $display("FAIL reset_state: got v=%b d=%h fd=%b a=%h expected 0 0000 0 0",
                  pix_valid, pix_data, frame_done, mem_addr);
      else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_stream();
      stream_frame(0, -1, 0, -1, 0, -1, -1, 1'b1);
      repeat (5) @(negedge clk_out);
      n_checks++;
      if (frame_done !== 1'b1 || pix_valid !== 1'b0)
         $display("FAIL done_hold: got fd=%b v=%b expected 1 0", frame_done, pix_valid);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      fill_rom();
      apply_reset();
      stream_frame(0, 10, 5, -1, 0, -1, -1, 1'b0);
   endtask

   task automatic test_img_switch();
      int w = 0;
      fill_rom();
      img_sel = 2'd0;
      apply_reset();
      stream_frame(0, -1, 0, 20, 1, -1, -1, 1'b0);
      while (frame_done && w < 10) begin
         @(negedge clk_out);
         w++;
      end
      n_checks++;
      if (w != 2) $display("FAIL frame_done_drop: got %0d cycles expected 2", w);
      else n_pass++;
      stream_frame(1, -1, 0, -1, 0, -1, -1, 1'b0);
   endtask

   task automatic test_mid_reset();
      fill_rom();
      img_sel = 2'd1;
      apply_reset();
      stream_frame(1, -1, 0, -1, 0, 30, -1, 1'b0);
      stream_frame(1, -1, 0, -1, 0, -1, -1, 1'b0);
   endtask

   task automatic test_key();
      fill_rom();
      rom[1] = KEY;
      img_sel = 2'd0;
      apply_reset();
      stream_frame(0, -1, 0, -1, 0, -1, -1, 1'b0);
   endtask

   task automatic test_bad_sel();
      fill_rom();
      img_sel = 2'd3;
      apply_reset();
      stream_frame(3, -1, 0, -1, 0, -1, 3, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         int nv;
         nv = int'($urandom_range(0, 2));
         if (nv == int'(img_sel)) nv = (nv + 1) % NI;
         @(negedge clk_out);
         img_sel = 2'(nv);
         stream_frame(nv, int'($urandom_range(0, NPIX - 1)), int'($urandom_range(1, 4)),
                      -1, 0, -1, nv*SW*SH + SW*SH - 1, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_img_switch();
      test_mid_reset();
      test_key();
      test_bad_sel();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
